frame_draw_sequencer: RTL and testbench
=======================================

Name: frame_draw_sequencer

Overview:
- Per-frame draw scheduler for the 160x120, 3-bit-colour VGA write port.
- On each frame tick, while the game is running, it:
  - erases the previous player and obstacle boxes;
  - redraws the obstacle, then the player;
  - evaluates player/obstacle overlap and end-of-screen into sticky flags.
- Sole owner of the plot/x/y/colour bus. The game FSM consumes its collided/reached_end flags.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- PW, 4, player box width
- PH, 4, player box height
- OW, 4, obstacle box width
- OH, 8, obstacle box height
- BG_COLOUR, 3'b000, erase colour
- PLAYER_COLOUR, 3'b111, player fill colour
- OBS_COLOUR, 3'b010, obstacle fill colour

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- run  in  1  game in play state; frames start only while high
- clear  in  1  clears collided/reached_end (new game)
- player_x  in  8  player box top-left x
- player_y  in  7  player box top-left y
- obs_x  in  8  obstacle box top-left x
- obs_y  in  7  obstacle box top-left y
- plot  out  1  write strobe to VGA adapter
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- collided  out  1  sticky overlap flag
- reached_end  out  1  sticky end-of-screen flag

Behaviour:
- Reset (synchronous, active-high, clock clock):
  - State to IDLE.
  - plot, vga_x, vga_y, vga_colour, busy, frame_done, collided, reached_end all 0.
  - Old-position shadow registers to (0,0).
  - Reset mid-frame aborts immediately; plot is 0 from the next cycle.
- States: IDLE, LATCH, ERASE_P, ERASE_O, DRAW_O, DRAW_P, DONE.
- IDLE -> LATCH when frame_tick & run.
  - LATCH (1 cycle) copies the current new-position registers to old, then samples the inputs into new.
  - Inputs are ignored for the rest of the frame.
- Each box state walks its box in raster order, x inner, one pixel per cycle, then moves to the next state:
  - ERASE_P: old player box, PW*PH cycles, BG_COLOUR.
  - ERASE_O: old obstacle box, OW*OH cycles, BG_COLOUR.
  - DRAW_O: new obstacle box, OW*OH cycles, OBS_COLOUR.
  - DRAW_P: new player box, PW*PH cycles, PLAYER_COLOUR.
  - Player is drawn last so it is on top.
- DONE (1 cycle): frame_done=1 and flags update, then IDLE.
- Latency: frame_done is high exactly 2+2*(PW*PH+OW*OH) cycles after the edge sampling frame_tick (98 with defaults).
- plot/vga_x/vga_y/vga_colour are registered and change together.
- Clipping: pixel with x>=SCREEN_W or y>=SCREEN_H uses its cycle but drives plot=0.
  - All coordinate sums use 9-bit arithmetic, so there is no wrap.
- frame_tick arriving while busy is dropped; no queueing.
- run falling mid-frame: the frame completes normally. No new frame starts while run=0.
- collided set in DONE if the new boxes overlap:
  - px<ox+OW and ox<px+PW and py<oy+OH and oy<py+PH, strict (touching edges do not collide).
- reached_end set in DONE if px+PW>=SCREEN_W.
- Flag priority: reset > clear > set. If clear and DONE coincide, flags end at 0.
- First frame after reset erases a box at (0,0).

Optional Feature:
- Macro: FSEQ_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt[7:0], reset to 0.
  - Increments on each frame_tick sampled while busy=1; saturates at 255.
  - Cleared by clear.
- Undefined: port absent; dropped ticks are silent.

Test Plan:
- Reset, then run=1, frame_tick at player (10,50), obs (80,46) -> 96 plot cycles in order erase(0,0) x2, obs, player; frame_done 98 cycles after tick; collided=0, reached_end=0.
- Second frame, player (78,48), obs (80,46) -> collided=1 at frame_done; stays 1 through further frames until clear pulse -> 0.
- Player (156,50) -> reached_end=1; player (155,50) -> reached_end=0 (boundary 155+4=159<160).
- Player x=158 -> pixels at x=160,161 drive plot=0 while timing is unchanged; no write to x=0/1.
- frame_tick pulsed 10 cycles into a frame -> ignored, one frame_done only; with FSEQ_OVERRUN_CNT_EN, overrun_cnt=1.
- Assert reset during DRAW_O -> plot=0 next cycle, busy=0, flags 0; next tick starts a clean frame erasing (0,0).

Source files
------------

// File: rtl/frame_draw_sequencer_if.sv
// Bundle between the frame draw sequencer (master) and its consumers:
// frame control, box positions, the VGA write bus and game status flags.
interface frame_draw_sequencer_if;
  logic       frame_tick;
  logic       run;
  logic       clear;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] obs_x;
  logic [6:0] obs_y;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       busy;
  logic       frame_done;
  logic       collided;
  logic       reached_end;

  modport master (
    input  frame_tick, run, clear, player_x, player_y, obs_x, obs_y,
    output plot, vga_x, vga_y, vga_colour, busy, frame_done, collided, reached_end
  );

  modport slave (
    output frame_tick, run, clear, player_x, player_y, obs_x, obs_y,
    input  plot, vga_x, vga_y, vga_colour, busy, frame_done, collided, reached_end
  );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Per-frame erase/redraw scheduler for the 160x120 VGA write port, with sticky
// collision and end-of-screen flags. Define FSEQ_OVERRUN_CNT_EN to count dropped frame ticks.
module frame_draw_sequencer #(
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter int         PW            = 4,
  parameter int         PH            = 4,
  parameter int         OW            = 4,
  parameter int         OH            = 8,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] PLAYER_COLOUR = 3'b111,
  parameter logic [2:0] OBS_COLOUR    = 3'b010
) (
  input  logic                    clock,
  input  logic                    reset,
  frame_draw_sequencer_if.master  bus
`ifdef FSEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]              overrun_cnt
`endif
);

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);
  localparam logic [8:0] PW9 = 9'(PW);
  localparam logic [8:0] PH9 = 9'(PH);
  localparam logic [8:0] OW9 = 9'(OW);
  localparam logic [8:0] OH9 = 9'(OH);
  localparam logic [7:0] PW8 = 8'(PW);
  localparam logic [7:0] PH8 = 8'(PH);
  localparam logic [7:0] OW8 = 8'(OW);
  localparam logic [7:0] OH8 = 8'(OH);

  typedef enum logic [2:0] {IDLE, LATCH, ERASE_P, ERASE_O, DRAW_O, DRAW_P, DONE} state_t;

  state_t     state, state_next, box_after;
  logic [7:0] col, row, col_next, row_next;
  logic [7:0] new_px, old_px, new_ox, old_ox;
  logic [6:0] new_py, old_py, new_oy, old_oy;
  logic [7:0] box_x0, box_w, box_h;
  logic [6:0] box_y0;
  logic [2:0] box_colour;
  logic [8:0] pix_x, pix_y;
  logic       pix_on, plot_next, hit, end_hit;

  logic       plot_q, done_q, collided_q, reached_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;

  // Box selection, pixel address generation and raster walk.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    box_x0     = new_px;
    box_y0     = new_py;
    box_w      = PW8;
    box_h      = PH8;
    box_colour = PLAYER_COLOUR;
    box_after  = DONE;
    pix_on     = 1'b0;
    case (state)
      ERASE_P: begin
        box_x0 = old_px; box_y0 = old_py; box_colour = BG_COLOUR;
        box_after = ERASE_O; pix_on = 1'b1;
      end
      ERASE_O: begin
        box_x0 = old_ox; box_y0 = old_oy; box_w = OW8; box_h = OH8;
        box_colour = BG_COLOUR; box_after = DRAW_O; pix_on = 1'b1;
      end
      DRAW_O: begin
        box_x0 = new_ox; box_y0 = new_oy; box_w = OW8; box_h = OH8;
        box_colour = OBS_COLOUR; box_after = DRAW_P; pix_on = 1'b1;
      end
      DRAW_P:  pix_on = 1'b1;
      default: ;
    endcase
    pix_x     = {1'b0, box_x0} + {1'b0, col};
    pix_y     = {2'b0, box_y0} + {1'b0, row};
    plot_next = pix_on && (pix_x < SW9) && (pix_y < SH9);

    case (state)
      IDLE:    if (bus.frame_tick && bus.run) state_next = LATCH;
      LATCH: begin
        state_next = ERASE_P;
        col_next   = 8'd0;
        row_next   = 8'd0;
      end
      ERASE_P, ERASE_O, DRAW_O, DRAW_P: begin
        if (col == box_w - 8'd1) begin
          col_next = 8'd0;
          if (row == box_h - 8'd1) begin
            row_next   = 8'd0;
            state_next = box_after;
          end else begin
            row_next = row + 8'd1;
          end
        end else begin
          col_next = col + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      col   <= 8'd0;
      row   <= 8'd0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // Strict overlap: boxes that merely touch along an edge do not collide.
  assign hit = ({1'b0, new_px} < {1'b0, new_ox} + OW9) && ({1'b0, new_ox} < {1'b0, new_px} + PW9) &&
               ({2'b0, new_py} < {2'b0, new_oy} + OH9) && ({2'b0, new_oy} < {2'b0, new_py} + PH9);
  assign end_hit = ({1'b0, new_px} + PW9) >= SW9;

  always_ff @(posedge clock) begin
    if (reset) begin
      plot_q       <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      done_q       <= 1'b0;
      collided_q   <= 1'b0;
      reached_q    <= 1'b0;
      new_px <= 8'd0; new_py <= 7'd0; new_ox <= 8'd0; new_oy <= 7'd0;
      old_px <= 8'd0; old_py <= 7'd0; old_ox <= 8'd0; old_oy <= 7'd0;
    end else begin
      plot_q <= plot_next;
      if (pix_on) begin
        vga_x_q      <= pix_x[7:0];
        vga_y_q      <= pix_y[6:0];
        vga_colour_q <= box_colour;
      end
      done_q <= (state == DONE);
      if (state == LATCH) begin
        old_px <= new_px; old_py <= new_py; old_ox <= new_ox; old_oy <= new_oy;
        new_px <= bus.player_x; new_py <= bus.player_y;
        new_ox <= bus.obs_x;    new_oy <= bus.obs_y;
      end
      if (bus.clear) begin
        collided_q <= 1'b0;
        reached_q  <= 1'b0;
      end else if (state == DONE) begin
        if (hit)     collided_q <= 1'b1;
        if (end_hit) reached_q  <= 1'b1;
      end
    end
  end

`ifdef FSEQ_OVERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || bus.clear) overrun_cnt <= 8'd0;
    else if (bus.frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

  assign bus.plot        = plot_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = done_q;
  assign bus.collided    = collided_q;
  assign bus.reached_end = reached_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Self-checking bench for frame_draw_sequencer: scoreboarded pixel stream,
// frame latency, sticky flags, clipping, dropped ticks and mid-frame reset.
module tb_frame_draw_sequencer;

  typedef struct {
    int px; int py; int ox; int oy;
    bit do_clear; bit exp_col; bit exp_end;
  } vec_t;

  typedef struct { int x; int y; int c; } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  frame_draw_sequencer_if bus ();
`ifdef FSEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  frame_draw_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FSEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   passes = 0;
  pix_t sb[$];
  int   m_old_px = 0, m_old_py = 0, m_old_ox = 0, m_old_oy = 0;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic void pushBox(input int x0, input int y0, input int w, input int h, input int c);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        p.x = x0 + k; p.y = y0 + r; p.c = c;
        if (p.x < 160 && p.y < 120) sb.push_back(p);
      end
  endfunction

  // Model of one frame: erase old boxes, draw obstacle then player.
  function automatic void pushFrame(input int px, input int py, input int ox, input int oy);
    pushBox(m_old_px, m_old_py, 4, 4, 0);
    pushBox(m_old_ox, m_old_oy, 4, 8, 0);
    pushBox(ox, oy, 4, 8, 2);
    pushBox(px, py, 4, 4, 7);
    m_old_px = px; m_old_py = py; m_old_ox = ox; m_old_oy = oy;
  endfunction

  task automatic pulseTick();
    @(negedge clock) bus.frame_tick = 1'b1;
    @(posedge clock);
    #1 bus.frame_tick = 1'b0;
  endtask

  task automatic setPositions(input int px, input int py, input int ox, input int oy);
    @(negedge clock);
    bus.player_x = 8'(px); bus.player_y = 7'(py);
    bus.obs_x    = 8'(ox); bus.obs_y    = 7'(oy);
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock); #1;
      if (bus.frame_done) begin lat = n; break; end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    setPositions(v.px, v.py, v.ox, v.oy);
    if (v.do_clear) begin
      bus.clear = 1'b1;
      @(posedge clock);
      #1 bus.clear = 1'b0;
      checkOutput("clear_collided", int'(bus.collided), 0);
      checkOutput("clear_reached_end", int'(bus.reached_end), 0);
    end
    pushFrame(v.px, v.py, v.ox, v.oy);
    pulseTick();
  endtask

  // Every plotted pixel must match the next expected write, in order.
  always @(negedge clock) begin
    pix_t p;
    if (!reset && bus.plot) begin
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_plot: got (%0d,%0d,%0d) expected no write",
                 bus.vga_x, bus.vga_y, bus.vga_colour);
      end else begin
        p = sb.pop_front();
        if (int'(bus.vga_x) == p.x && int'(bus.vga_y) == p.y && int'(bus.vga_colour) == p.c)
          passes++;
        else
          $display("[TB] FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   bus.vga_x, bus.vga_y, bus.vga_colour, p.x, p.y, p.c);
      end
    end
  end

  initial begin
    int lat;
    int extra;
    vecs[0] = '{px:10,  py:50, ox:80, oy:46, do_clear:0, exp_col:0, exp_end:0};
    vecs[1] = '{px:78,  py:48, ox:80, oy:46, do_clear:0, exp_col:1, exp_end:0};
    vecs[2] = '{px:10,  py:50, ox:80, oy:46, do_clear:0, exp_col:1, exp_end:0};
    vecs[3] = '{px:156, py:50, ox:80, oy:46, do_clear:0, exp_col:1, exp_end:1};
    vecs[4] = '{px:76,  py:46, ox:80, oy:46, do_clear:1, exp_col:0, exp_end:0};
    vecs[5] = '{px:155, py:50, ox:80, oy:46, do_clear:0, exp_col:0, exp_end:0};
    vecs[6] = '{px:158, py:50, ox:80, oy:46, do_clear:0, exp_col:0, exp_end:1};

    bus.frame_tick = 1'b0; bus.run = 1'b0; bus.clear = 1'b0;
    bus.player_x = 8'd0; bus.player_y = 7'd0; bus.obs_x = 8'd0; bus.obs_y = 7'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_plot", int'(bus.plot), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_frame_done", int'(bus.frame_done), 0);
    checkOutput("reset_collided", int'(bus.collided), 0);
    checkOutput("reset_reached_end", int'(bus.reached_end), 0);
    checkOutput("reset_vga_x", int'(bus.vga_x), 0);
    reset = 1'b0;

    // Ticks are ignored while the game is not running.
    pulseTick();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("run0_busy", int'(bus.busy), 0);
    checkOutput("run0_plot", int'(bus.plot), 0);

    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitDone(lat);
      checkOutput($sformatf("latency_%0d", i), lat, 98);
      checkOutput($sformatf("collided_%0d", i), int'(bus.collided), int'(vecs[i].exp_col));
      checkOutput($sformatf("reached_end_%0d", i), int'(bus.reached_end), int'(vecs[i].exp_end));
      checkOutput($sformatf("pixels_left_%0d", i), sb.size(), 0);
    end

    // A second tick 10 cycles into a frame is dropped.
    setPositions(156, 50, 80, 46);
    pushFrame(156, 50, 80, 46);
    pulseTick();
    repeat (9) @(posedge clock);
    pulseTick();
    waitDone(lat);
    checkOutput("drop_latency", lat, 88);
    checkOutput("drop_reached_end", int'(bus.reached_end), 1);
    checkOutput("drop_collided", int'(bus.collided), 0);
    extra = 0;
    for (int n = 0; n < 120; n++) begin
      @(posedge clock); #1;
      if (bus.frame_done || bus.busy) extra++;
    end
    checkOutput("drop_extra_frames", extra, 0);
    checkOutput("drop_pixels_left", sb.size(), 0);
`ifdef FSEQ_OVERRUN_CNT_EN
    checkOutput("overrun_cnt", int'(overrun_cnt), 1);
`endif

    // Reset in the middle of the obstacle draw.
    setPositions(10, 50, 80, 46);
    pushFrame(10, 50, 80, 46);
    pulseTick();
    repeat (60) @(posedge clock);
    #1;
    checkOutput("mid_busy", int'(bus.busy), 1);
    checkOutput("mid_plot", int'(bus.plot), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort_plot", int'(bus.plot), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_collided", int'(bus.collided), 0);
    checkOutput("abort_reached_end", int'(bus.reached_end), 0);
`ifdef FSEQ_OVERRUN_CNT_EN
    checkOutput("abort_overrun_cnt", int'(overrun_cnt), 0);
`endif
    reset = 1'b0;
    sb.delete();
    m_old_px = 0; m_old_py = 0; m_old_ox = 0; m_old_oy = 0;

    // Clean frame after reset erases boxes at the origin.
    setPositions(30, 20, 100, 60);
    pushFrame(30, 20, 100, 60);
    pulseTick();
    waitDone(lat);
    checkOutput("post_reset_latency", lat, 98);
    checkOutput("post_reset_collided", int'(bus.collided), 0);
    checkOutput("post_reset_reached_end", int'(bus.reached_end), 0);
    checkOutput("post_reset_pixels_left", sb.size(), 0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
